// File: rtl/parking_meter_ctrl.sv
// Parking meter controller: remaining-seconds counter with add/set pulses,
// 1 Hz countdown from a 2 Hz strobe, and EXPIRED/LOW/HIGH display behaviour.
module parking_meter_ctrl #(
  parameter int MAX_SEC = 3599,
  parameter int LOW_SEC = 180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_2hz,
  input  logic        add60,
  input  logic        add120,
  input  logic        add180,
  input  logic        add300,
  input  logic        set15,
  input  logic        set150,
  output logic [11:0] sec_count,
  output logic        display_on,
  output logic        expired,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_EXPIRED = 2'b00,
    ST_LOW     = 2'b01,
    ST_HIGH    = 2'b10
  } state_t;

  localparam logic [12:0] MAX13 = 13'(MAX_SEC);
  localparam logic [11:0] LOW12 = 12'(LOW_SEC);

  state_t      state_q;
  state_t      state_d;
  logic        half_ph;
  logic        half_d;
  logic        sec_tick;
  logic [12:0] add_sum;
  logic [12:0] sum;
  logic [12:0] tmp;
  logic [11:0] sec_d;
  logic        disp_d;

  assign state = state_q;

  always_comb begin
    add_sum  = 13'd0;
    sum      = 13'd0;
    tmp      = 13'd0;
    sec_d    = sec_count;
    half_d   = half_ph;
    state_d  = state_q;
    disp_d   = display_on;
    sec_tick = tick_2hz & half_ph;

    add_sum = (add60  ? 13'd60  : 13'd0) + (add120 ? 13'd120 : 13'd0)
            + (add180 ? 13'd180 : 13'd0) + (add300 ? 13'd300 : 13'd0);
    sum = {1'b0, sec_count} + add_sum;
    tmp = (sum > MAX13) ? MAX13 : sum;

    // A set restarts the half-second phase so the next full second is two ticks away.
    if (set15 || set150) begin
      sec_d  = set150 ? 12'd150 : 12'd15;
      half_d = 1'b0;
    end else begin
      half_d = half_ph ^ tick_2hz;
      if (sec_tick && tmp != 13'd0) sec_d = 12'(tmp - 13'd1);
      else                          sec_d = tmp[11:0];
    end

    if (sec_d == 12'd0)     state_d = ST_EXPIRED;
    else if (sec_d < LOW12) state_d = ST_LOW;
    else                    state_d = ST_HIGH;

    case (state_d)
      ST_HIGH: disp_d = 1'b1;
      ST_LOW:  disp_d = ~sec_d[0];
      default: begin
        if (state_q != ST_EXPIRED) disp_d = 1'b0;
        else if (tick_2hz)         disp_d = ~display_on;
        else                       disp_d = display_on;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sec_count  <= 12'd0;
      state_q    <= ST_EXPIRED;
      expired    <= 1'b1;
      display_on <= 1'b1;
      half_ph    <= 1'b0;
    end else begin
      sec_count  <= sec_d;
      state_q    <= state_d;
      expired    <= (sec_d == 12'd0);
      display_on <= disp_d;
      half_ph    <= half_d;
    end
  end

endmodule

// File: doc/parking_meter_ctrl.md
PARKING_METER_CTRL -- requirements
Module: parking_meter_ctrl

Interface
REQ-001 Parameter MAX_SEC, default 3599, is the saturation ceiling of the remaining-time counter (59:59).
REQ-002 Parameter LOW_SEC, default 180, is the threshold below which remaining time is "low".
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 tick_2hz  input  1  one-cycle strobe, every 0.5 s.
REQ-006 add60, add120, add180, add300  input  1 each  one-cycle debounced pulses; each adds its stated number of seconds.
REQ-007 set15, set150  input  1 each  one-cycle debounced pulses; each loads 15 s or 150 s.
REQ-008 sec_count  output  12  registered remaining seconds, 0..MAX_SEC; drives the minutes/seconds digit converter.
REQ-009 display_on  output  1  registered; 1 = digits lit, 0 = digits blanked.
REQ-010 expired  output  1  registered; 1 when sec_count == 0.
REQ-011 state  output  2  registered; 00 EXPIRED, 01 LOW, 10 HIGH.

Function
REQ-012 An internal half-second phase bit, half_ph, SHALL toggle on every tick_2hz; sec_tick = tick_2hz AND half_ph==1.
REQ-013 add_sum SHALL be the sum of all add pulses asserted in the same cycle (0..660), computed 13 bits wide.
REQ-014 If set15 or set150 is asserted, next sec_count SHALL be 150 if set150 else 15; set150 wins over set15; adds and sec_tick in that cycle are ignored; half_ph clears to 0.
REQ-015 Otherwise, tmp = min(sec_count + add_sum, MAX_SEC), and next sec_count = tmp - 1 if sec_tick and tmp > 0, else tmp.
REQ-016 sec_count SHALL never wrap below 0 or exceed MAX_SEC.
REQ-017 Next state SHALL derive from next sec_count: 0 -> EXPIRED; 1..LOW_SEC-1 -> LOW; >= LOW_SEC -> HIGH. state, expired and sec_count update in the same cycle.
REQ-018 HIGH: display_on SHALL be 1.
REQ-019 LOW: display_on SHALL equal NOT next sec_count[0] (lit on even seconds, blanked on odd: 2 s period).
REQ-020 EXPIRED: display_on SHALL toggle on every tick_2hz (1 Hz blink); on entry into EXPIRED from LOW/HIGH, display_on SHALL be 0.
REQ-021 Leaving EXPIRED via add or set SHALL apply REQ-018/019 in the same cycle.
REQ-022 Latency: every input pulse is reflected on all outputs exactly one clk edge later.
REQ-023 No input pulse is lost; pulses held longer than one cycle apply once per cycle held.

Reset
REQ-024 When rst_n == 0 at a rising edge: sec_count = 0, state = EXPIRED, expired = 1, display_on = 1, half_ph = 0; all other inputs ignored that cycle.
REQ-025 Reset asserted mid-countdown SHALL take effect at that edge with no partial decrement or add.

Verification
REQ-026 Reset, then 4 tick_2hz -> sec_count stays 0, expired = 1, display_on sequence 0,1,0,1 after each tick.
REQ-027 set150, then 2 tick_2hz -> sec_count 150 then 149; state LOW; display_on 1 at 150, 0 at 149.
REQ-028 From 3500, add300 -> sec_count 3599 (saturated), state HIGH, display_on = 1; add60+add120 same cycle from 0 -> 180, HIGH.
REQ-029 sec_count 1, add60 coinciding with sec_tick -> sec_count 60; sec_count 1 with sec_tick alone -> 0, state EXPIRED, display_on 0, expired 1.
REQ-030 set15 and set150 together with add300 and sec_tick -> sec_count 150, half_ph 0; next sec_tick arrives two tick_2hz later.
REQ-031 Sweep: set150, adds to 3599, then 7200 tick_2hz -> sec_count decrements once per two ticks to 0; state boundaries exactly at 179/180 and 0.
